// File: rtl/binary_clock_top.sv
// binary_clock_top: 24-hour binary wall clock.
// HH:MM kept as BCD digits dh1:dh0:dm1:dm0, advanced by a seconds prescaler
// or by an active-low set button (one minute per MAIN_CLK/8 cycles).
// LED[3:0] shows dm0, LED[4] is a 1 Hz heartbeat.
// Optional macro WS2812_EN: when defined, the digits are rendered as a
// 4x4 binary matrix on a 16-pixel WS2812 chain; otherwise WS2812_DATA is 0.
module binary_clock_top #(
   parameter int          MAIN_CLK   = 12000000,
   parameter logic [23:0] LED_COLOUR = 24'h001F00
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN,
   output logic [4:0] LED,
   output logic       WS2812_DATA
);

   localparam int SET_DIV = (MAIN_CLK / 8 > 1) ? MAIN_CLK / 8 : 1;
   localparam int PW      = $clog2(MAIN_CLK);
   localparam int SW      = (SET_DIV > 1) ? $clog2(SET_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(MAIN_CLK - 1);
   localparam logic [SW-1:0] SET_MAX   = SW'(SET_DIV - 1);

   logic          btn_meta, btn_sync, pressed;
   logic [PW-1:0] presc;
   logic          tick, heartbeat;
   logic [SW-1:0] set_cnt;
   logic          set_step;
   logic [5:0]    sec;
   logic          min_inc;
   logic [3:0]    dh1, dh0, dm1, dm0;

   // Two-flop synchronizer for the asynchronous button; idles released.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         btn_meta <= 1'b1;
         btn_sync <= 1'b1;
      end else begin
         btn_meta <= BTN;
         btn_sync <= btn_meta;
      end
   end

   assign pressed = ~btn_sync;
   assign tick    = (presc == PRESC_MAX);

   // Free-running one-second prescaler and heartbeat toggle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         presc     <= '0;
         heartbeat <= 1'b0;
      end else if (tick) begin
         presc     <= '0;
         heartbeat <= ~heartbeat;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Set-step divider, restarted whenever the button is released.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         set_cnt <= '0;
      end else if (!pressed || set_cnt == SET_MAX) begin
         set_cnt <= '0;
      end else begin
         set_cnt <= set_cnt + SW'(1);
      end
   end

   assign set_step = pressed && (set_cnt == SET_MAX);

   // Seconds 0..59, held at zero while setting.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sec <= '0;
      end else if (pressed) begin
         sec <= '0;
      end else if (tick) begin
         sec <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
      end
   end

   // Seconds are held during set, so carry and set-step are mutually exclusive.
   assign min_inc = (!pressed && tick && sec == 6'd59) || set_step;

   // BCD minute/hour carry chain with 23:59 -> 00:00 wrap.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dh1 <= '0;
         dh0 <= '0;
         dm1 <= '0;
         dm0 <= '0;
      end else if (min_inc) begin
         if (dm0 == 4'd9) begin
            dm0 <= '0;
            if (dm1 == 4'd5) begin
               dm1 <= '0;
               if (dh1 == 4'd2 && dh0 == 4'd3) begin
                  dh1 <= '0;
                  dh0 <= '0;
               end else if (dh0 == 4'd9) begin
                  dh0 <= '0;
                  dh1 <= dh1 + 4'd1;
               end else begin
                  dh0 <= dh0 + 4'd1;
               end
            end else begin
               dm1 <= dm1 + 4'd1;
            end
         end else begin
            dm0 <= dm0 + 4'd1;
         end
      end
   end

   assign LED = {heartbeat, dm0};

`ifdef WS2812_EN
   localparam int T_BIT = (MAIN_CLK / 800000 > 3) ? MAIN_CLK / 800000 : 3;
   localparam int T0H   = (T_BIT / 3 > 1) ? T_BIT / 3 : 1;
   localparam int T1H   = ((2 * T_BIT) / 3 > 2) ? (2 * T_BIT) / 3 : 2;
   localparam int T_RST = (MAIN_CLK / 16000 > 2) ? MAIN_CLK / 16000 : 2;
   localparam int CMAX  = (T_BIT > T_RST) ? T_BIT : T_RST;
   localparam int CW    = $clog2(CMAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_BIT, S_GAP} ws_state_t;

   ws_state_t   state, state_nxt;
   logic [CW-1:0] cyc;
   logic [3:0]  pix;
   logic [4:0]  pbit;
   logic [15:0] frame;
   logic [23:0] shreg;
   logic        bit_end, last_bit, gap_end;
   logic        data_d, data_q;

   assign bit_end  = (cyc == CW'(T_BIT - 1));
   assign last_bit = (pix == 4'd15) && (pbit == 5'd23);
   assign gap_end  = (cyc == CW'(T_RST - 1));

   // Serializer state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state: latch, 384 bits, reset gap, repeat.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_BIT;
         S_BIT:   if (bit_end && last_bit) state_nxt = S_GAP;
         S_GAP:   if (gap_end) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Line level: high for T1H/T0H at the start of each bit slot.
   always_comb begin
      data_d = 1'b0;
      if (state == S_BIT)
         data_d = shreg[23] ? (cyc < CW'(T1H)) : (cyc < CW'(T0H));
   end

   // Frame datapath: digits latched at frame start, pixel and bit shifters,
   // and a registered output so the pin is glitch-free.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cyc    <= '0;
         pix    <= '0;
         pbit   <= '0;
         frame  <= '0;
         shreg  <= '0;
         data_q <= 1'b0;
      end else begin
         data_q <= data_d;
         case (state)
            S_IDLE: begin
               frame <= {dh1, dh0, dm1, dm0};
               shreg <= dh1[3] ? LED_COLOUR : '0;
               cyc   <= '0;
               pix   <= '0;
               pbit  <= '0;
            end
            S_BIT: begin
               if (bit_end) begin
                  cyc <= '0;
                  if (pbit == 5'd23) begin
                     pbit  <= '0;
                     pix   <= pix + 4'd1;
                     frame <= {frame[14:0], 1'b0};
                     shreg <= frame[14] ? LED_COLOUR : '0;
                  end else begin
                     pbit  <= pbit + 5'd1;
                     shreg <= {shreg[22:0], 1'b0};
                  end
               end else begin
                  cyc <= cyc + CW'(1);
               end
            end
            default: cyc <= gap_end ? '0 : cyc + CW'(1);
         endcase
      end
   end

   assign WS2812_DATA = data_q;
`else
   logic unused_colour;
   assign unused_colour = ^LED_COLOUR;
   assign WS2812_DATA   = 1'b0;
`endif

endmodule

// File: tb/tb_binary_clock_top.sv
// Directed bench for binary_clock_top at MAIN_CLK=2 (tick every 2 cycles,
// one set-step per cycle). With WS2812_EN defined it also decodes a frame.
module tb_binary_clock_top;

   logic       CLK;
   logic       RST;
   logic       BTN;
   logic [4:0] LED;
   logic       WS2812_DATA;

   int checks   = 0;
   int failures = 0;
   int illegal  = 0;
   int ws_high  = 0;

   binary_clock_top #(.MAIN_CLK(2), .LED_COLOUR(24'h001F00)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .BTN         (BTN),
      .LED         (LED),
      .WS2812_DATA (WS2812_DATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle just after the last one.
   task automatic wait_clks(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Expected BCD digits for a minute-of-day value.
   function automatic logic [15:0] hhmm(input int m);
      int mm, hh, mi;
      mm = m % 1440;
      hh = mm / 60;
      mi = mm % 60;
      return {4'(hh / 10), 4'(hh % 10), 4'(mi / 10), 4'(mi % 10)};
   endfunction

   function automatic logic [15:0] digits();
      return {dut.dh1, dut.dh0, dut.dm1, dut.dm0};
   endfunction

   // Flags any out-of-range digit and any activity on an absent serializer.
   always @(negedge CLK) begin
      if (!RST) begin
         if (dut.dm0 > 9 || dut.dm1 > 5 || dut.dh0 > 9 || dut.dh1 > 2 ||
             (dut.dh1 == 2 && dut.dh0 > 3) || dut.sec > 59)
            illegal++;
         if (WS2812_DATA) ws_high++;
      end
   end

   initial begin
      logic [23:0] pixval [16];
      int lowrun, h, l, terr;
      logic found;

      RST = 1'b1;
      BTN = 1'b1;
      wait_clks(3);
      check("rst_time", digits(), 16'h0000);
      check("rst_led", LED, 5'h00);
      check("rst_sec", dut.sec, 0);
      check("rst_ws", WS2812_DATA, 0);
      RST = 1'b0;

      // Free run: tick on every even edge, 60 ticks per minute.
      wait_clks(119);
      check("run119_time", digits(), hhmm(0));
      check("run119_sec", dut.sec, 59);
      check("run119_led", LED, 5'h10);
      wait_clks(1);
      check("run120_time", digits(), hhmm(1));
      check("run120_sec", dut.sec, 0);
      check("run120_led", LED, 5'h01);
      wait_clks(1);
      check("hb_121", LED, 5'h01);
      wait_clks(1);
      check("hb_122", LED, 5'h11);

      // Set mode: two edges of sync latency, then one minute per edge.
      BTN = 1'b0;
      wait_clks(2);
      check("set_latency", digits(), hhmm(1));
      wait_clks(1);
      check("set_first", digits(), hhmm(2));
      check("set_sec_held", dut.sec, 0);
      wait_clks(750);
      check("set_run", digits(), hhmm(752));
      // Release also takes two edges to reach the synchronizer output.
      BTN = 1'b1;
      wait_clks(2);
      check("set_1234", digits(), hhmm(12 * 60 + 34));
      check("led_1234", LED[3:0], 4'd4);
      wait_clks(118);
      check("hold_1234", digits(), hhmm(12 * 60 + 34));
      check("hold_sec", dut.sec, 59);
      wait_clks(1);
      check("resume_1235", digits(), hhmm(12 * 60 + 35));
      check("resume_sec", dut.sec, 0);

      // Fast set across midnight.
      BTN = 1'b0;
      wait_clks(686);
      check("set_2359", digits(), hhmm(23 * 60 + 59));
      check("set_2359_sec", dut.sec, 0);
      wait_clks(1);
      check("set_wrap", digits(), hhmm(0));
      wait_clks(1437);
      BTN = 1'b1;
      wait_clks(2);
      check("park_2359", digits(), hhmm(23 * 60 + 59));
      wait_clks(119);
      check("tick_2359_59", digits(), hhmm(23 * 60 + 59));
      check("tick_sec59", dut.sec, 59);
      wait_clks(1);
      check("tick_wrap", digits(), hhmm(0));
      check("tick_wrap_led", LED[3:0], 4'd0);

`ifdef WS2812_EN
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (WS2812_DATA) found = 1'b1;
         else wait_clks(1);
      end
      check("ws_active", found, 1);
`endif
      // Reset asserted between edges (mid-frame when the serializer exists).
      RST = 1'b1;
      #1;
      check("rst_abort_ws", WS2812_DATA, 0);
      check("rst_abort_time", digits(), 16'h0000);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      wait_clks(1);
`ifdef WS2812_EN
      check("frame0_idle", WS2812_DATA, 0);
`endif
      wait_clks(1);
`ifdef WS2812_EN
      check("frame0_start", WS2812_DATA, 1);
`endif
      // Edge 491: time is 00:04; set to 10:07 with the release lead-in.
      wait_clks(489);
      BTN = 1'b0;
      wait_clks(603);
      BTN = 1'b1;
      wait_clks(2);
      check("set_1007", digits(), hhmm(10 * 60 + 7));

`ifdef WS2812_EN
      // Find the inter-frame gap (longer than any in-frame low), then decode
      // the frame latched while 10:07 is held.
      lowrun = 0;
      found  = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         wait_clks(1);
         if (!WS2812_DATA) lowrun++;
         else if (lowrun >= 4) found = 1'b1;
         else lowrun = 0;
      end
      check("frame1_found", found, 1);
      check("gap_len", lowrun >= 3, 1);
      terr = 0;
      for (int p = 0; p < 16; p++) pixval[p] = '0;
      for (int b = 0; b < 384; b++) begin
         h = 0;
         while (WS2812_DATA && h < 20) begin
            h++;
            wait_clks(1);
         end
         l = 0;
         if (b < 383) begin
            while (!WS2812_DATA && l < 20) begin
               l++;
               wait_clks(1);
            end
            if (h + l != 3) terr++;
         end
         if (h != 1 && h != 2) terr++;
         pixval[b / 24] = {pixval[b / 24][22:0], (h == 2)};
      end
      check("bit_timing", terr, 0);
      // 10:07 -> dh1=0001 dh0=0000 dm1=0000 dm0=0111: pixels 3,13,14,15 lit.
      for (int p = 0; p < 16; p++) begin
         check($sformatf("pix%0d", p), pixval[p],
               (p == 3 || p == 13 || p == 14 || p == 15) ? 24'h001F00 : 24'h000000);
      end
`else
      check("ws_tied_low", ws_high, 0);
`endif

      check("legal_digits", illegal, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/binary_clock_top.md
Name: binary_clock_top

Overview:
Top level of a 24-hour binary wall clock. Keeps HH:MM time as four BCD digits from a free-running seconds prescaler, accepts an active-low set button that fast-advances the time, and renders the digits as a 4x4 binary matrix on a WS2812 LED chain plus five discrete status LEDs. Sits directly on the FPGA pins; the only submodules are internal.

Parameters:
MAIN_CLK, 12000000, CLK frequency in Hz; one second = MAIN_CLK cycles. Must be >=2; benches use 2.
LED_COLOUR, 24'h001F00, GRB value sent for a lit matrix pixel; unlit pixels send 24'h000000.

Ports:
CLK  input  1  system clock, all logic rising-edge.
RST  input  1  asynchronous active-high reset.
BTN  input  1  set button, active low, asynchronous to CLK.
LED  output 5  LED[3:0] = dm0 in binary; LED[4] = 1 Hz heartbeat.
WS2812_DATA  output 1  serial data to the 16-pixel WS2812 chain.

Behaviour:
- Reset (RST high, async): dh1=dh0=dm1=dm0=0, second counter 0, prescaler 0, heartbeat 0, WS2812_DATA 0, serializer idle. Frames start after RST deasserts.
- Internal digit registers are named dh1, dh0, dm1, dm0 (4 bits each, BCD) at the top level; benches probe them hierarchically.
- Prescaler counts 0..MAIN_CLK-1; tick pulses one cycle at the wrap. On tick: heartbeat toggles, seconds 0..59 increment.
- Seconds wrap 59->0 carries into minutes. dm0 0..9 wraps to 0 and increments dm1 (0..5); dm1 wrap carries into hours. Hours: dh0 0..9 with dh1 0..2; 23:59 wraps to 00:00. Illegal states never occur.
- BTN passes through a 2-flop synchronizer; pressed = synchronized value 0.
- While pressed: seconds counter held at 0, normal tick ignored; a set-step fires every SET_DIV = max(1, MAIN_CLK/8) cycles and adds one minute with full carry chain (8 min/s at real rate). Release resumes normal counting from seconds=0.
- A minute carry and a set-step never coincide (seconds held during set); no double increment.
- WS2812 frame: 16 pixels; pixel i (0..15) = digit (0:dh1,1:dh0,2:dm1,3:dm0)[i/4], bit 3-(i%4); lit sends LED_COLOUR else 0. 24 bits/pixel, MSB first.
- Bit timing in cycles: T_BIT = max(3, MAIN_CLK/800000); T0H = max(1, T_BIT/3); T1H = max(2, (2*T_BIT)/3). Each bit: high for T0H/T1H then low to T_BIT.
- After 384 bits, DATA low for T_RST = max(2, MAIN_CLK/16000) cycles (>=60 us), then next frame. Digits are latched at frame start; mid-frame digit changes appear next frame.
- Reset mid-frame aborts immediately, DATA goes low.

Optional Feature:
WS2812_EN: defined -> serializer as above. Undefined -> no serializer logic; WS2812_DATA tied 0; clock/LED behaviour unchanged.

Test Plan:
- MAIN_CLK=2, BTN=1, pulse RST -> all digits 0, LED=0; after 120 CLK cycles dm0=1; LED[4] toggles every 2 cycles.
- BTN=1 free run -> time reaches dh1=2,dh0=3 then wraps to dh1=0,dh0=0 after 86400 s (172800 cycles); dm1 never exceeds 5, dh0 never exceeds 3 when dh1=2.
- After wrap, BTN=0 -> one minute per SET_DIV (1) cycle after 2-cycle sync latency; 23:xx then 00:00 reached within 1440 steps; seconds held 0.
- Release BTN mid-set at 12:34 -> time holds 12:34 for 60 ticks then 12:35.
- WS2812_EN, MAIN_CLK=12000000, time 10:07 -> frame pixels 0001 0000 0000 0111 lit per mapping; T_BIT 15, T0H 5, T1H 10, low gap >=750 cycles.
- Assert RST mid-frame -> WS2812_DATA 0 same cycle, digits 0, next frame starts cleanly after release.
